// File: rtl/std_fp_div_pkg.sv
// Shared types and sizing helpers for the iterative fixed-point divider.
package std_fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // One restoring step per dividend bit; the dividend carries FRAC extra zero bits.
    function automatic int calc_iters(input int width, input int frac_width);
        return width + frac_width;
    endfunction

    function automatic int calc_cnt_w(input int width, input int frac_width);
        return $clog2(calc_iters(width, frac_width) + 1);
    endfunction

    localparam int DEF_ITERS = calc_iters(8, 4);
    localparam int DEF_CNT_W = $clog2(DEF_ITERS + 1);

endpackage

// File: rtl/std_fp_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module std_fp_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Two guard bits: shifted stays below 2*divisor, so the MSB of trial is a clean sign.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[WIDTH+1];
        rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/std_fp_div_iter.sv
// Iterative fixed-point divider, go/done handshake, one quotient bit per cycle.
module std_fp_div_iter
    import std_fp_div_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int INT_WIDTH  = 4,
    parameter int FRAC_WIDTH = 4,
    parameter int SIGNED     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
);

    localparam int ITERS = calc_iters(WIDTH, FRAC_WIDTH);
    localparam int CNT_W = calc_cnt_w(WIDTH, FRAC_WIDTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ITERS-1:0]     dvd_q, dvd_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic [WIDTH-1:0]     left_q, left_d;
    logic                 sl_q, sl_d;
    logic                 sr_q, sr_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     out_quotient_q, out_quotient_d;
    logic [WIDTH-1:0]     out_remainder_q, out_remainder_d;
    logic                 done_q, done_d;

    logic                 left_neg, right_neg;
    logic [WIDTH-1:0]     left_mag, right_mag;
    logic [WIDTH-1:0]     q_mag, r_mag;
    logic [WIDTH:0]       step_rem;
    logic                 step_q;

    std_fp_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[ITERS-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // The most-negative operand negates to itself, which reads correctly as unsigned.
    always_comb begin
        left_neg  = (SIGNED != 0) && left[WIDTH-1];
        right_neg = (SIGNED != 0) && right[WIDTH-1];
        left_mag  = left_neg  ? (~left  + WIDTH'(1)) : left;
        right_mag = right_neg ? (~right + WIDTH'(1)) : right;
        q_mag     = dvd_q[WIDTH-1:0];
        r_mag     = rem_q[WIDTH-1:0];
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        dvd_d           = dvd_q;
        rem_d           = rem_q;
        dsr_d           = dsr_q;
        left_d          = left_q;
        sl_d            = sl_q;
        sr_d            = sr_q;
        dz_d            = dz_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
        done_d          = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    sl_d    = left_neg;
                    sr_d    = right_neg;
                    dz_d    = (right == '0);
                    left_d  = left;
                    dsr_d   = right_mag;
                    dvd_d   = {left_mag, {FRAC_WIDTH{1'b0}}};
                    rem_d   = '0;
                    cnt_d   = CNT_W'(ITERS);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!go) begin
                    state_d = IDLE;
                end else begin
                    // The dividend register doubles as the quotient shift register.
                    dvd_d = {dvd_q[ITERS-2:0], step_q};
                    rem_d = step_rem;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = FIX;
                end
            end
            FIX: begin
                if (!go) begin
                    state_d = IDLE;
                end else begin
                    if (dz_q) begin
                        out_quotient_d  = '1;
                        out_remainder_d = left_q;
                    end else begin
                        out_quotient_d  = (sl_q ^ sr_q) ? (~q_mag + WIDTH'(1)) : q_mag;
                        out_remainder_d = sl_q ? (~r_mag + WIDTH'(1)) : r_mag;
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            dvd_q           <= '0;
            rem_q           <= '0;
            dsr_q           <= '0;
            left_q          <= '0;
            sl_q            <= 1'b0;
            sr_q            <= 1'b0;
            dz_q            <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dvd_q           <= dvd_d;
            rem_q           <= rem_d;
            dsr_q           <= dsr_d;
            left_q          <= left_d;
            sl_q            <= sl_d;
            sr_q            <= sr_d;
            dz_q            <= dz_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
            done_q          <= done_d;
        end
    end

    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign done          = done_q;

endmodule
